// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Hits answer one cycle after acceptance; misses fetch a single word from the
// memory controller, fill the line and then answer.
module icache_direct #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        fetch_accept,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_instr,
  input  logic [31:0] mem_instr_addr,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned LINES   = 1 << INDEX_BITS;
  localparam int unsigned TAG_LSB = INDEX_BITS + 2;
  localparam int unsigned TAG_MSB = TAG_LSB + TAG_BITS - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MISS    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [TAG_BITS-1:0]   tag_d  [LINES];
  logic [31:0]           data_q [LINES];
  logic [31:0]           data_d [LINES];
  logic [31:0]           pending_pc_q, pending_pc_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic [31:0]           out_pc_q, out_pc_d;
  logic                  mem_req_q, mem_req_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;

  logic [INDEX_BITS-1:0] req_idx, pend_idx;
  logic [TAG_BITS-1:0]   req_tag, pend_tag;
  logic                  req_hit;
  logic                  fill_match;

  // Lookup of the incoming request and decode of the pending miss address.
  assign req_idx      = fetch_pc[INDEX_BITS+1:2];
  assign req_tag      = fetch_pc[TAG_MSB:TAG_LSB];
  assign pend_idx     = pending_pc_q[INDEX_BITS+1:2];
  assign pend_tag     = pending_pc_q[TAG_MSB:TAG_LSB];
  assign req_hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_match   = mem_ready && (mem_instr_addr == pending_pc_q);
  assign fetch_accept = rdy && !rst && !rob_clear && (state_q == IDLE) && fetch_valid;

  // Next-state, fill and response logic; rob_clear overrides every state.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    pending_pc_d = pending_pc_q;
    out_valid_d  = 1'b0;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    if (rob_clear) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_accept) begin
            if (req_hit) begin
              out_valid_d = 1'b1;
              out_instr_d = data_q[req_idx];
              out_pc_d    = fetch_pc;
              hit_cnt_d   = (hit_cnt_q == 32'hFFFF_FFFF) ? hit_cnt_q : hit_cnt_q + 32'd1;
            end else begin
              pending_pc_d = {fetch_pc[31:2], 2'b00};
              mem_req_d    = 1'b1;
              mem_addr_d   = {fetch_pc[31:2], 2'b00};
              state_d      = MISS;
              miss_cnt_d   = (miss_cnt_q == 32'hFFFF_FFFF) ? miss_cnt_q : miss_cnt_q + 32'd1;
            end
          end
        end
        MISS: begin
          if (fill_match) begin
            valid_d[pend_idx] = 1'b1;
            tag_d[pend_idx]   = pend_tag;
            data_d[pend_idx]  = mem_instr;
            mem_req_d         = 1'b0;
            state_d           = RESPOND;
          end
        end
        RESPOND: begin
          out_valid_d = 1'b1;
          out_instr_d = data_q[pend_idx];
          out_pc_d    = pending_pc_q;
          state_d     = IDLE;
        end
        default: begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      pending_pc_q <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      pending_pc_q <= pending_pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Tag and data arrays need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_icache_direct.sv
// Directed, table-driven bench for icache_direct: each record drives one
// cycle of inputs and lists the expected accept and registered outputs.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst, rdy, rob_clear, fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_accept, out_valid, mem_req, mem_ready;
  logic [31:0] out_instr, out_pc, mem_addr, mem_instr, mem_instr_addr;
  logic [31:0] hit_cnt, miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache_direct dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_accept(fetch_accept),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_instr(mem_instr), .mem_instr_addr(mem_instr_addr),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    logic        rst, rdy, clr, fv;
    logic [31:0] pc;
    logic        mr;
    logic [31:0] mi, mia;
    logic        acc, ov;
    logic [31:0] oi, opc;
    logic        mreq;
    logic [31:0] maddr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic c, input logic fv,
                              input logic [31:0] pc, input logic mr, input logic [31:0] mi,
                              input logic [31:0] mia, input logic acc, input logic ov,
                              input logic [31:0] oi, input logic [31:0] opc,
                              input logic mreq, input logic [31:0] maddr);
    vec_t v;
    v.rst = r; v.rdy = rd; v.clr = c; v.fv = fv; v.pc = pc; v.mr = mr; v.mi = mi;
    v.mia = mia; v.acc = acc; v.ov = ov; v.oi = oi; v.opc = opc; v.mreq = mreq;
    v.maddr = maddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle: check the combinational accept, then the registered outputs.
  task automatic step(input vec_t v, input string nm);
    rst = v.rst; rdy = v.rdy; rob_clear = v.clr; fetch_valid = v.fv; fetch_pc = v.pc;
    mem_ready = v.mr; mem_instr = v.mi; mem_instr_addr = v.mia;
    #1;
    chk({nm, ".accept"}, 32'(fetch_accept), 32'(v.acc));
    @(posedge clk);
    #1;
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(v.ov));
    if (v.ov) begin
      chk({nm, ".out_instr"}, out_instr, v.oi);
      chk({nm, ".out_pc"}, out_pc, v.opc);
    end
    chk({nm, ".mem_req"}, 32'(mem_req), 32'(v.mreq));
    if (v.mreq) chk({nm, ".mem_addr"}, mem_addr, v.maddr);
  endtask

  // Shorthands: plain request / memory return / idle cycle with rdy=1, no flush.
  function automatic vec_t rq(input logic [31:0] pc, input logic acc, input logic ov,
                              input logic [31:0] oi, input logic [31:0] opc,
                              input logic mreq, input logic [31:0] maddr);
    return mk(0, 1, 0, 1, pc, 0, 0, 0, acc, ov, oi, opc, mreq, maddr);
  endfunction

  function automatic vec_t mret(input logic [31:0] mi, input logic [31:0] mia,
                                input logic mreq, input logic [31:0] maddr);
    return mk(0, 1, 0, 0, 0, 1, mi, mia, 0, 0, 0, 0, mreq, maddr);
  endfunction

  function automatic vec_t idl(input logic ov, input logic [31:0] oi, input logic [31:0] opc,
                               input logic mreq, input logic [31:0] maddr);
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, ov, oi, opc, mreq, maddr);
  endfunction

  vec_t tbl[23];

  initial begin
    // Cold miss on 0x1000, response after four waiting cycles.
    tbl[0]  = rq(32'h1000, 1, 0, 0, 0, 1, 32'h1000);
    tbl[1]  = idl(0, 0, 0, 1, 32'h1000);
    tbl[2]  = idl(0, 0, 0, 1, 32'h1000);
    tbl[3]  = idl(0, 0, 0, 1, 32'h1000);
    tbl[4]  = mret(32'h0050_0093, 32'h1000, 0, 0);
    tbl[5]  = idl(1, 32'h0050_0093, 32'h1000, 0, 0);
    // Warm 0x1004.
    tbl[6]  = rq(32'h1004, 1, 0, 0, 0, 1, 32'h1004);
    tbl[7]  = mret(32'h00A0_0113, 32'h1004, 0, 0);
    tbl[8]  = idl(1, 32'h00A0_0113, 32'h1004, 0, 0);
    // Back-to-back hits.
    tbl[9]  = rq(32'h1000, 1, 1, 32'h0050_0093, 32'h1000, 0, 0);
    tbl[10] = rq(32'h1004, 1, 1, 32'h00A0_0113, 32'h1004, 0, 0);
    tbl[11] = idl(0, 0, 0, 0, 0);
    // Conflict: 0x1100 evicts 0x1000, which then misses again.
    tbl[12] = rq(32'h1100, 1, 0, 0, 0, 1, 32'h1100);
    tbl[13] = mret(32'h1111_1111, 32'h1100, 0, 0);
    tbl[14] = idl(1, 32'h1111_1111, 32'h1100, 0, 0);
    tbl[15] = rq(32'h1000, 1, 0, 0, 0, 1, 32'h1000);
    tbl[16] = mret(32'h0050_0093, 32'h1000, 0, 0);
    tbl[17] = idl(1, 32'h0050_0093, 32'h1000, 0, 0);
    // Mismatched return ignored (request presented during MISS not taken).
    tbl[18] = rq(32'h3000, 1, 0, 0, 0, 1, 32'h3000);
    tbl[19] = mk(0, 1, 0, 1, 32'h1000, 1, 32'hDEAD_BEEF, 32'h2FFC, 0, 0, 0, 0, 1, 32'h3000);
    tbl[20] = mret(32'h0BAD_F00D, 32'h3000, 0, 0);
    // Request during RESPOND is not taken; afterwards 0x3000 hits.
    tbl[21] = rq(32'h1000, 0, 1, 32'h0BAD_F00D, 32'h3000, 0, 0);
    tbl[22] = rq(32'h3000, 1, 1, 32'h0BAD_F00D, 32'h3000, 0, 0);

    rst = 1; rdy = 1; rob_clear = 0; fetch_valid = 0; fetch_pc = 0;
    mem_ready = 0; mem_instr = 0; mem_instr_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("reset.accept", 32'(fetch_accept), 32'd0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_instr", out_instr, 32'd0);
    chk("reset.out_pc", out_pc, 32'd0);
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.hit_cnt", hit_cnt, 32'd0);
    chk("reset.miss_cnt", miss_cnt, 32'd0);

    for (int i = 0; i < 23; i++) step(tbl[i], $sformatf("vec%0d", i));
    chk("table.hit_cnt", hit_cnt, 32'd3);
    chk("table.miss_cnt", miss_cnt, 32'd5);

    // Flush mid-miss; a flush-cycle request is not taken; late return ignored.
    step(rq(32'h2000, 1, 0, 0, 0, 1, 32'h2000), "flush.miss");
    step(idl(0, 0, 0, 1, 32'h2000), "flush.wait");
    step(mk(0, 1, 1, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "flush.clear");
    step(mret(32'h1234_5678, 32'h2000, 0, 0), "flush.late_ret");
    step(rq(32'h2000, 1, 0, 0, 0, 1, 32'h2000), "flush.remiss");
    // Flush coinciding with the return: no fill.
    step(mk(0, 1, 1, 0, 0, 1, 32'h1234_5678, 32'h2000, 0, 0, 0, 0, 0, 0), "flush.coincide");
    step(rq(32'h2000, 1, 0, 0, 0, 1, 32'h2000), "flush.remiss2");
    chk("flush.hit_cnt", hit_cnt, 32'd3);
    chk("flush.miss_cnt", miss_cnt, 32'd8);

    // rdy stall during MISS, even with a matching return on the bus.
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 0, 1, 32'h1000, 1, 32'hCAFE_F00D, 32'h2000, 0, 0, 0, 0, 1, 32'h2000),
           $sformatf("stall.miss%0d", i));
    chk("stall.miss_cnt", miss_cnt, 32'd8);
    step(mret(32'hCAFE_F00D, 32'h2000, 0, 0), "stall.fill");
    step(idl(1, 32'hCAFE_F00D, 32'h2000, 0, 0), "stall.respond");
    // rdy stall while out_valid is high: outputs hold.
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 0, 1, 32'h2000, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 32'h2000, 0, 0),
           $sformatf("stall.out%0d", i));
    chk("stall.hit_cnt", hit_cnt, 32'd3);
    step(rq(32'h2000, 1, 1, 32'hCAFE_F00D, 32'h2000, 0, 0), "stall.hit");
    step(idl(0, 0, 0, 0, 0), "stall.idle");
    chk("stall.hit_cnt2", hit_cnt, 32'd4);

    // rst mid-MISS aborts the miss and invalidates every line.
    step(rq(32'h4000, 1, 0, 0, 0, 1, 32'h4000), "rst.miss");
    step(mk(1, 1, 0, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst.apply");
    chk("rst.hit_cnt", hit_cnt, 32'd0);
    chk("rst.miss_cnt", miss_cnt, 32'd0);
    step(rq(32'h1000, 1, 0, 0, 0, 1, 32'h1000), "rst.cold");
    step(mret(32'h7777_7777, 32'h1000, 0, 0), "rst.fill");
    step(idl(1, 32'h7777_7777, 32'h1000, 0, 0), "rst.respond");
    chk("rst.miss_cnt2", miss_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
